// File: rtl/tetris_grid_render.sv
// tetris_grid_render: draws the Tetris playfield from a once-per-frame snapshot of
// the live grid through a three-stage classify/lookup/palette pipeline, one RGB332 pixel per clock.
module tetris_grid_render #(
  parameter int X0        = 240,
  parameter int Y0        = 80,
  parameter int CELL_LOG2 = 4,
  parameter int BORDER    = 4
) (
  input  logic                  clk,
  input  logic                  nRst_i,
  input  logic [20:0][9:0][2:0] grid,
  input  logic                  frame_start,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic                  de,
  output logic [7:0]            rgb_o,
  output logic                  de_o
);

  localparam logic [9:0] X0_V    = 10'(X0);
  localparam logic [9:0] Y0_V    = 10'(Y0);
  localparam logic [9:0] FIELD_W = 10'(10 << CELL_LOG2);
  localparam logic [9:0] FIELD_H = 10'(20 << CELL_LOG2);
  localparam logic [9:0] BOX_X0  = 10'(X0 - BORDER);
  localparam logic [9:0] BOX_Y0  = 10'(Y0 - BORDER);
  localparam logic [9:0] BOX_W   = 10'((10 << CELL_LOG2) + 2 * BORDER);
  localparam logic [9:0] BOX_H   = 10'((20 << CELL_LOG2) + 2 * BORDER);

  function automatic logic [7:0] palette(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'h00;
      3'd1:    c = 8'h1F;
      3'd2:    c = 8'h03;
      3'd3:    c = 8'hF0;
      3'd4:    c = 8'hFC;
      3'd5:    c = 8'h1C;
      3'd6:    c = 8'h63;
      3'd7:    c = 8'hE0;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  logic [20:0][9:0][2:0] shadow_q, shadow_d;
  logic                  snap_valid_q, snap_valid_d;

  logic [9:0] dx_s, dy_s, bx_s, by_s;
  logic       in_field_s, in_box_s;

  logic [3:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic       edge1_q, edge1_d;
  logic       field1_q, field1_d;
  logic       border1_q, border1_d;
  logic       de1_q, de1_d;

  logic [2:0] idx_q, idx_d;
  logic       edge2_q, edge2_d;
  logic       field2_q, field2_d;
  logic       border2_q, border2_d;
  logic       de2_q, de2_d;

  logic [7:0] rgb_q, rgb_d;
  logic       de3_q, de3_d;

  // Next-state for snapshot and all three pipeline stages
  always_comb begin
    shadow_d     = frame_start ? grid : shadow_q;
    snap_valid_d = snap_valid_q | frame_start;

    // Offsets wrap modulo 1024, so a single unsigned compare covers both range ends
    dx_s       = hcount - X0_V;
    dy_s       = vcount - Y0_V;
    bx_s       = hcount - BOX_X0;
    by_s       = vcount - BOX_Y0;
    in_field_s = (dx_s < FIELD_W) && (dy_s < FIELD_H);
    in_box_s   = (bx_s < BOX_W) && (by_s < BOX_H);

    col_d     = dx_s[CELL_LOG2 +: 4];
    row_d     = dy_s[CELL_LOG2 +: 5] + 5'd1;
    edge1_d   = (dx_s[CELL_LOG2-1:0] == {CELL_LOG2{1'b0}}) ||
                (dy_s[CELL_LOG2-1:0] == {CELL_LOG2{1'b0}});
    field1_d  = in_field_s;
    border1_d = in_box_s && !in_field_s;
    de1_d     = de;

    if (field1_q && snap_valid_q) begin
      idx_d = shadow_q[row_q][col_q];
    end else begin
      idx_d = 3'd0;
    end
    edge2_d   = edge1_q;
    field2_d  = field1_q;
    border2_d = border1_q;
    de2_d     = de1_q;

    if (!de2_q) begin
      rgb_d = 8'h00;
    end else if (border2_q) begin
      rgb_d = 8'hFF;
    end else if (field2_q && (idx_q == 3'd0) && edge2_q) begin
      rgb_d = 8'h49;
    end else if (field2_q) begin
      rgb_d = palette(idx_q);
    end else begin
      rgb_d = 8'h00;
    end
    de3_d = de2_q;
  end

  // Registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nRst_i) begin
      shadow_q     <= {630{1'b0}};
      snap_valid_q <= 1'b0;
      col_q        <= 4'd0;
      row_q        <= 5'd0;
      edge1_q      <= 1'b0;
      field1_q     <= 1'b0;
      border1_q    <= 1'b0;
      de1_q        <= 1'b0;
      idx_q        <= 3'd0;
      edge2_q      <= 1'b0;
      field2_q     <= 1'b0;
      border2_q    <= 1'b0;
      de2_q        <= 1'b0;
      rgb_q        <= 8'h00;
      de3_q        <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      snap_valid_q <= snap_valid_d;
      col_q        <= col_d;
      row_q        <= row_d;
      edge1_q      <= edge1_d;
      field1_q     <= field1_d;
      border1_q    <= border1_d;
      de1_q        <= de1_d;
      idx_q        <= idx_d;
      edge2_q      <= edge2_d;
      field2_q     <= field2_d;
      border2_q    <= border2_d;
      de2_q        <= de2_d;
      rgb_q        <= rgb_d;
      de3_q        <= de3_d;
    end
  end

  assign rgb_o = rgb_q;
  assign de_o  = de3_q;

endmodule

// File: tb/tb_tetris_grid_render.sv
// Randomized plus directed bench for tetris_grid_render, checked every cycle against
// a per-pixel reference model of the playfield drawing rules.
module tb_tetris_grid_render;

  logic                  clk;
  logic                  nRst_i;
  logic [20:0][9:0][2:0] grid;
  logic                  frame_start;
  logic [9:0]            hcount;
  logic [9:0]            vcount;
  logic                  de;
  logic [7:0]            rgb_o;
  logic                  de_o;

  tetris_grid_render dut (
    .clk         (clk),
    .nRst_i      (nRst_i),
    .grid        (grid),
    .frame_start (frame_start),
    .hcount      (hcount),
    .vcount      (vcount),
    .de          (de),
    .rgb_o       (rgb_o),
    .de_o        (de_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fails  = 0;
  int         ms [21][10];
  bit         mvalid;
  logic [7:0] pal [8];
  logic [7:0] e_rgb [3];
  bit         e_de [3];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pixel colour from the drawing rules, using the model snapshot
  function automatic logic [7:0] ref_pix(input int h, input int v, input bit d);
    bit fld, brd, on_line;
    int c, r, idx;
    if (!d) return 8'h00;
    fld = (h >= 240) && (h < 400) && (v >= 80) && (v < 400);
    brd = !fld && (h >= 236) && (h < 404) && (v >= 76) && (v < 404);
    if (brd) return 8'hFF;
    if (!fld) return 8'h00;
    c       = (h - 240) / 16;
    r       = (v - 80) / 16 + 1;
    idx     = mvalid ? ms[r][c] : 0;
    on_line = ((h - 240) % 16 == 0) || ((v - 80) % 16 == 0);
    if (idx == 0 && on_line) return 8'h49;
    return pal[idx];
  endfunction

  task automatic model_edge(input int h, input int v, input bit d, input bit fs, input bit rst);
    if (rst) begin
      for (int r = 0; r < 21; r++)
        for (int c = 0; c < 10; c++) ms[r][c] = 0;
      mvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        e_rgb[i] = 8'h00;
        e_de[i]  = 1'b0;
      end
    end else begin
      if (fs) begin
        for (int r = 0; r < 21; r++)
          for (int c = 0; c < 10; c++) ms[r][c] = int'(grid[r][c]);
        mvalid = 1'b1;
      end
      e_rgb[2] = e_rgb[1];
      e_de[2]  = e_de[1];
      e_rgb[1] = e_rgb[0];
      e_de[1]  = e_de[0];
      e_rgb[0] = ref_pix(h, v, d);
      e_de[0]  = d;
    end
  endtask

  task automatic step(input int h, input int v, input bit d, input bit fs, input bit rst);
    hcount      = 10'(h);
    vcount      = 10'(v);
    de          = d;
    frame_start = fs;
    nRst_i      = !rst;
    @(posedge clk);
    model_edge(h, v, d, fs, rst);
    #1;
    check("rgb", rgb_o, e_rgb[2]);
    check("de_o", {7'd0, de_o}, {7'd0, e_de[2]});
  endtask

  // Single pixel followed by two blank cycles, then compare against a fixed colour
  task automatic probe(input string tag, input int h, input int v, input logic [7:0] exp);
    step(h, v, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b0);
    check(tag, rgb_o, exp);
  endtask

  initial begin
    pal = '{8'h00, 8'h1F, 8'h03, 8'hF0, 8'hFC, 8'h1C, 8'h63, 8'hE0};
    grid = {630{1'b0}};
    hcount = 10'd0; vcount = 10'd0; de = 1'b0; frame_start = 1'b0; nRst_i = 1'b0;

    // Reset with de high
    step(236, 200, 1'b1, 1'b0, 1'b1);
    step(236, 200, 1'b1, 1'b0, 1'b1);
    check("reset_rgb", rgb_o, 8'h00);
    check("reset_de", {7'd0, de_o}, 8'h00);
    probe("border_nosnap", 236, 200, 8'hFF);
    probe("line_nosnap", 240, 96, 8'h49);

    // Occupied cell
    grid[1][0] = 3'd1;
    step(0, 0, 1'b0, 1'b1, 1'b0);
    probe("occupied", 241, 81, 8'h1F);
    probe("occupied_edge", 240, 80, 8'h1F);

    // Empty cells, border, outside
    grid = {630{1'b0}};
    step(0, 0, 1'b0, 1'b1, 1'b0);
    probe("grid_line", 272, 96, 8'h49);
    probe("empty_cell", 273, 97, 8'h00);
    probe("border_left", 237, 200, 8'hFF);
    probe("outside", 100, 100, 8'h00);
    step(300, 300, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b0);
    check("de_low", rgb_o, 8'h00);

    // Hidden row and tear-free snapshot
    for (int c = 0; c < 10; c++) grid[0][c] = 3'd7;
    grid[20][9] = 3'd6;
    step(0, 0, 1'b0, 1'b1, 1'b0);
    probe("last_cell", 399, 399, 8'h63);
    for (int v = 76; v < 80; v++) probe("top_border", 300, v, 8'hFF);
    grid[20][9] = 3'd2;
    probe("tear_free", 399, 399, 8'h63);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    probe("resnap", 399, 399, 8'h03);

    // Back-to-back sweep with a snapshot mid-line
    grid = {630{1'b0}};
    for (int c = 0; c < 10; c++) grid[1][c] = 3'(c % 8);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) grid[1][c] = 3'((c + 3) % 8);
    for (int h = 236; h <= 404; h++) step(h, 81, 1'b1, (h == 310), 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b0);

    // Random traffic with held frame_start, grid churn and mid-frame resets
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++)
        grid[$urandom_range(0, 20)][$urandom_range(0, 9)] = 3'($urandom_range(0, 7));
      step($urandom_range(220, 420), $urandom_range(60, 420),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < 4),
           ($urandom_range(0, 999) < 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/tetris_grid_render.md
# tetris_grid_render

Pixel renderer and the read side of the Tetris playfield grid. Consumes the 21×10×3-bit `grid` driven by `tetris_fsm` together with VGA beam coordinates, and produces one RGB332 pixel per clock. Output is tear-free: the grid is snapshotted once per frame. Rows 1–20 are drawn as a 10×20 cell field with a white border; row 0 is the hidden spawn row.

## Interface
Parameters:
- `X0`, default 240: left pixel column of the field interior.
- `Y0`, default 80: top pixel row of the field interior (grid row 1).
- `CELL_LOG2`, default 4: log2 of the cell edge in pixels (16 px).
- `BORDER`, default 4: border thickness in pixels.

Ports:
- `clk`, input, 1: pixel clock; the block has a single clock.
- `nRst_i`, input, 1: synchronous, active-low reset.
- `grid`, input, [20:0][9:0][2:0]: live playfield as `[row][col][color]`; color 0 = empty.
- `frame_start`, input, 1: one-cycle pulse at the start of vertical blanking; triggers a snapshot.
- `hcount`, input, 10: beam x position.
- `vcount`, input, 10: beam y position.
- `de`, input, 1: display enable (active video).
- `rgb_o`, output, 8: pixel in RGB332 format.
- `de_o`, output, 1: `de` delayed to align with `rgb_o`.

## Operation
Snapshot:
- When `frame_start` = 1, `shadow <= grid` on that edge and `snap_valid <= 1`.
- `grid` is not read at any other time. Changes to `grid` between pulses never reach `rgb_o`.

Pipeline, three registered stages:
- **S1 (classify).** All arithmetic is unsigned 10-bit.
  - `dx = hcount - X0`, `dy = vcount - Y0`.
  - `in_field` = `hcount` in [X0, X0+10·2^CELL_LOG2) AND `vcount` in [Y0, Y0+20·2^CELL_LOG2).
  - `in_border` = NOT `in_field` AND `hcount` in [X0-BORDER, X0+160+BORDER) AND `vcount` in [Y0-BORDER, Y0+320+BORDER). Bounds shown use defaults.
  - Register: `col = dx >> CELL_LOG2` (0–9); `row = (dy >> CELL_LOG2) + 1` (1–20); `edge` = low CELL_LOG2 bits of `dx` or of `dy` equal 0; `in_field`; `in_border`; `de`.
- **S2 (lookup).**
  - `idx = shadow[row][col]` when `in_field` AND `snap_valid`; otherwise 0.
  - Register `idx`, `edge`, `in_field`, `in_border`, `de`.
- **S3 (palette).** Priority order:
  1. `de` = 0 → 0x00.
  2. `in_border` → 0xFF.
  3. `in_field` AND `idx` = 0 AND `edge` → 0x49 (grid line).
  4. `in_field` → palette[`idx`].
  5. Otherwise → 0x00.
- Palette (RGB332): 0 → 0x00, 1 → 0x1F, 2 → 0x03, 3 → 0xF0, 4 → 0xFC, 5 → 0x1C, 6 → 0x63, 7 → 0xE0.
- Row 0 is never addressed. Out-of-range `row`/`col` values only occur when `in_field` = 0, and are then masked.

## Timing
- Reset (`nRst_i` = 0 at a rising edge):
  - `shadow`, `snap_valid`, and all pipeline registers clear to 0.
  - `rgb_o` = 0x00 and `de_o` = 0 from the next cycle.
  - Applies mid-frame as well. Pixels in flight are discarded, and the field renders empty with grid lines until the next `frame_start`.
- Latency: exactly 3 cycles from `hcount`/`vcount`/`de` to `rgb_o`/`de_o`. Throughput is one pixel per cycle with no stalls.
- `frame_start` in cycle N:
  - S2 lookups in cycle N+1 and later use the new snapshot.
  - A pixel that is in S2 during cycle N uses the old snapshot.
- `frame_start` held high for multiple cycles re-snapshots on every cycle it is high. This is legal.
- `frame_start` and `de` high together: both are honoured, per the cycle rule above.
- Before the first snapshot (`snap_valid` = 0): field interior shows 0x49 on edge pixels and 0x00 elsewhere; the border is drawn normally.

## Test plan
- **Reset:** hold `nRst_i` = 0 for 2 cycles while `de` = 1 → `rgb_o` = 0x00 and `de_o` = 0. With no snapshot yet, pixel (236,200) → 0xFF at +3 cycles.
- **Occupied cell:** set `grid[1][0]` = 1, pulse `frame_start`, drive (241,81) with `de` = 1 → `rgb_o` = 0x1F exactly 3 cycles later. Pixel (240,80), an edge pixel of an occupied cell, → 0x1F.
- **Empty cell, border, outside:** all cells empty.
  - Pixel (272,96), edge pixel → 0x49.
  - Pixel (273,97) → 0x00.
  - Pixel (237,200) → 0xFF.
  - Pixel (100,100) → 0x00.
  - Any pixel with `de` = 0 → 0x00.
- **Tear-free and hidden row:** set `grid[0][*]` = 7, set `grid[20][9]` = 6, snapshot.
  - Pixel (399,399) → 0x63.
  - Pixels at `vcount` 76–79 → 0xFF, never 0xE0.
  - Then change `grid[20][9]` = 2 without `frame_start` → still 0x63. After the next `frame_start` → 0x03.
- **Back-to-back sweep:** stream `hcount` 236..404 on `vcount` = 81 after snapshotting `grid[1][c] = c mod 8` (for `c` = 0–9) → output sequence:
  - border 0xFF for 4 pixels;
  - then 16 pixels per cell: the edge pixel is 0x49 where the cell is empty, and every other pixel uses the palette in column order;
  - then 0xFF for 4 pixels, then 0x00.
  - No gaps; constant 3-cycle offset.
- **Snapshot mid-line:** pulse `frame_start` at cycle N during the sweep → pixels entering S2 at N+1 or later reflect the new grid; earlier pixels reflect the old grid.
